// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the PC register controls, issues one memory read
// at a time and holds the returned word in a single-entry buffer for decode.
module instr_fetch #(
  parameter int WIDTH    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_inc,
  output logic             pc_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] ir_out,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             fetch_err
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state_reg;
  logic [CW-1:0]    wait_cnt_reg;
  logic [WIDTH-1:0] ir_out_reg;
  logic             ir_valid_reg;
  logic             fetch_err_reg;

  logic redirect_take;
  logic fetch_done;

  // A redirect only counts while a fetch is in flight or buffered; it outranks everything.
  assign redirect_take = redirect && ((state_reg == S_REQ) || (state_reg == S_HOLD));
  assign fetch_done    = (state_reg == S_REQ) && mem_ready && !redirect;

  assign pc_en     = redirect_take || fetch_done;
  assign pc_inc    = fetch_done;
  assign pc_next   = redirect_take ? redirect_target : '0;
  assign mem_rd    = (state_reg == S_REQ);
  assign mem_addr  = mem_rd ? pc_cur : '0;
  assign ir_out    = ir_out_reg;
  assign ir_valid  = ir_valid_reg;
  assign fetch_err = fetch_err_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg     <= S_IDLE;
      wait_cnt_reg  <= '0;
      ir_out_reg    <= '0;
      ir_valid_reg  <= 1'b0;
      fetch_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: state_reg <= S_REQ;
        S_REQ: begin
          if (redirect) begin
            wait_cnt_reg <= '0;
            state_reg    <= S_FLUSH;
          end else if (mem_ready) begin
            ir_out_reg   <= mem_data;
            ir_valid_reg <= 1'b1;
            wait_cnt_reg <= '0;
            state_reg    <= S_HOLD;
          end else if (wait_cnt_reg == CW'(WAIT_MAX - 1)) begin
            // WAIT_MAX consecutive cycles without mem_ready: give up for good.
            fetch_err_reg <= 1'b1;
            wait_cnt_reg  <= '0;
            state_reg     <= S_ERR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || ir_ready) begin
            ir_valid_reg <= 1'b0;
            state_reg    <= redirect ? S_FLUSH : S_REQ;
          end
        end
        S_FLUSH: state_reg <= S_REQ;
        S_ERR:   state_reg <= S_ERR;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC register alongside the DUT.
module tb_instr_fetch;

  localparam int W    = 32;
  localparam int WMAX = 6;

  logic         clk = 1'b0;
  logic         clr;
  logic [W-1:0] pc_cur;
  logic [W-1:0] pc_next;
  logic         pc_inc;
  logic         pc_en;
  logic [W-1:0] mem_addr;
  logic         mem_rd;
  logic         mem_ready;
  logic [W-1:0] mem_data;
  logic [W-1:0] ir_out;
  logic         ir_valid;
  logic         ir_ready;
  logic         redirect;
  logic [W-1:0] redirect_target;
  logic         fetch_err;

  logic         pc_load;
  logic [W-1:0] pc_load_val;
  int           pulse_cnt = 0;
  int           checks = 0;
  int           failures = 0;

  instr_fetch #(.WIDTH(W), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .clr(clr), .pc_cur(pc_cur), .pc_next(pc_next), .pc_inc(pc_inc),
    .pc_en(pc_en), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .mem_data(mem_data), .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_target(redirect_target), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // PC register: updates on the edge where pc_en is high.
  always @(posedge clk) begin
    if (pc_load) pc_cur <= pc_load_val;
    else if (pc_en) pc_cur <= pc_inc ? pc_cur + 1 : pc_next;
  end

  always @(posedge clk) if (pc_en && !clr) pulse_cnt <= pulse_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; mem_ready = 0; mem_data = '0; ir_ready = 0; redirect = 0;
    redirect_target = '0; pc_load = 1; pc_load_val = '0;
    tick(); tick();
    checks++;
    if ({mem_rd, pc_en, pc_inc, ir_valid, fetch_err} !== 5'b0 || mem_addr !== '0 ||
        pc_next !== '0 || ir_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%b en=%b inc=%b iv=%b err=%b addr=%h nxt=%h ir=%h required all 0",
               mem_rd, pc_en, pc_inc, ir_valid, fetch_err, mem_addr, pc_next, ir_out);
    end
    clr = 1'b0; pc_load = 0;
    $display("reset: released, outputs checked");
  endtask

  task automatic test_basic_fetch();
    int p0;
    p0 = pulse_cnt;
    tick();  // IDLE -> REQ
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h0 || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL fetch_req: rd=%b addr=%h en=%b required 1 0 0", mem_rd, mem_addr, pc_en);
    end
    tick(); tick();
    mem_ready = 1; mem_data = 32'hA5A5_0001; ir_ready = 1;
    #1;
    checks++;
    if (pc_en !== 1'b1 || pc_inc !== 1'b1 || pc_next !== '0) begin
      failures++;
      $display("FAIL fetch_pc_pulse: en=%b inc=%b nxt=%h required 1 1 0", pc_en, pc_inc, pc_next);
    end
    tick();
    mem_ready = 0; mem_data = '0;
    #1;
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 32'hA5A5_0001 || mem_rd !== 1'b0 || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL fetch_hold: iv=%b ir=%h rd=%b en=%b required 1 a5a50001 0 0",
               ir_valid, ir_out, mem_rd, pc_en);
    end
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h1 || ir_valid !== 1'b0 || pulse_cnt - p0 !== 1) begin
      failures++;
      $display("FAIL fetch_next: rd=%b addr=%h iv=%b pulses=%0d required 1 1 0 1",
               mem_rd, mem_addr, ir_valid, pulse_cnt - p0);
    end
    ir_ready = 0;
    $display("basic_fetch: ir=%h next_addr=%h", ir_out, mem_addr);
  endtask

  task automatic test_hold_stall();
    int p0;
    mem_ready = 1; mem_data = 32'h1111_2222;
    tick();
    mem_ready = 0; mem_data = '0;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ir_out !== 32'h1111_2222 || ir_valid !== 1'b1 || mem_rd !== 1'b0 || pc_en !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: ir=%h iv=%b rd=%b en=%b required 11112222 1 0 0",
                 i, ir_out, ir_valid, mem_rd, pc_en);
      end
    end
    ir_ready = 1;
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL hold_accept_cycle: rd=%b required 0", mem_rd);
    end
    tick();
    ir_ready = 0;
    #1;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h2 || ir_valid !== 1'b0 || pulse_cnt !== p0) begin
      failures++;
      $display("FAIL hold_refetch: rd=%b addr=%h iv=%b pulses=%0d required 1 2 0 0",
               mem_rd, mem_addr, ir_valid, pulse_cnt - p0);
    end
    $display("hold_stall: refetch at %h", mem_addr);
  endtask

  task automatic test_redirect();
    mem_ready = 1; mem_data = 32'hDEAD_BEEF; redirect = 1; redirect_target = 32'h40;
    #1;
    checks++;
    if (pc_en !== 1'b1 || pc_inc !== 1'b0 || pc_next !== 32'h40) begin
      failures++;
      $display("FAIL redir_req_pc: en=%b inc=%b nxt=%h required 1 0 40", pc_en, pc_inc, pc_next);
    end
    tick();
    mem_ready = 0; mem_data = '0; redirect = 0; redirect_target = '0;
    #1;
    checks++;
    if (ir_valid !== 1'b0 || ir_out !== 32'h1111_2222 || mem_rd !== 1'b0 || pc_en !== 1'b0 ||
        pc_next !== '0) begin
      failures++;
      $display("FAIL redir_flush: iv=%b ir=%h rd=%b en=%b nxt=%h required 0 11112222 0 0 0",
               ir_valid, ir_out, mem_rd, pc_en, pc_next);
    end
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL redir_target_fetch: rd=%b addr=%h required 1 40", mem_rd, mem_addr);
    end
    // Redirect coinciding with an ir handshake in HOLD.
    mem_ready = 1; mem_data = 32'h0000_0040;
    tick();
    mem_ready = 0; ir_ready = 1; redirect = 1; redirect_target = 32'h80;
    #1;
    checks++;
    if (pc_en !== 1'b1 || pc_inc !== 1'b0 || pc_next !== 32'h80 || ir_valid !== 1'b1) begin
      failures++;
      $display("FAIL redir_hold_pc: en=%b inc=%b nxt=%h iv=%b required 1 0 80 1",
               pc_en, pc_inc, pc_next, ir_valid);
    end
    tick();
    ir_ready = 0; redirect = 0; redirect_target = '0;
    #1;
    checks++;
    if (ir_valid !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL redir_hold_flush: iv=%b rd=%b required 0 0", ir_valid, mem_rd);
    end
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h80) begin
      failures++;
      $display("FAIL redir_hold_fetch: rd=%b addr=%h required 1 80", mem_rd, mem_addr);
    end
    $display("redirect: fetching from %h", mem_addr);
  endtask

  task automatic test_timeout();
    int p0;
    p0 = pulse_cnt;
    for (int i = 1; i < WMAX; i++) begin
      tick();
      checks++;
      if (fetch_err !== 1'b0 || mem_rd !== 1'b1) begin
        failures++;
        $display("FAIL timeout_early[%0d]: err=%b rd=%b required 0 1", i, fetch_err, mem_rd);
      end
    end
    tick();
    checks++;
    if (fetch_err !== 1'b1 || mem_rd !== 1'b0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: err=%b rd=%b iv=%b required 1 0 0", fetch_err, mem_rd, ir_valid);
    end
    redirect = 1; redirect_target = 32'h200; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fetch_err !== 1'b1 || pc_en !== 1'b0 || mem_rd !== 1'b0 || pc_next !== '0) begin
        failures++;
        $display("FAIL err_sticky[%0d]: err=%b en=%b rd=%b nxt=%h required 1 0 0 0",
                 i, fetch_err, pc_en, mem_rd, pc_next);
      end
    end
    redirect = 0; redirect_target = '0; mem_ready = 0;
    checks++;
    if (pulse_cnt !== p0) begin
      failures++;
      $display("FAIL timeout_pulses: got=%0d required 0", pulse_cnt - p0);
    end
    $display("timeout: fetch_err=%b", fetch_err);
  endtask

  task automatic test_async_clear();
    #2;
    clr = 1; pc_load = 1; pc_load_val = 32'h100;
    #1;
    checks++;
    if (fetch_err !== 1'b0 || mem_rd !== 1'b0 || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL clr_from_err: err=%b rd=%b en=%b required 0 0 0", fetch_err, mem_rd, pc_en);
    end
    tick();
    clr = 0; pc_load = 0;
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL clr_resume1: rd=%b addr=%h required 1 100", mem_rd, mem_addr);
    end
    // Mid-REQ, between edges, with a response pending.
    #2;
    mem_ready = 1; mem_data = 32'h5555_AAAA;
    #1;
    clr = 1;
    #1;
    checks++;
    if ({mem_rd, pc_en, pc_inc, ir_valid, fetch_err} !== 5'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL clr_mid_req: rd=%b en=%b inc=%b iv=%b err=%b addr=%h required all 0",
               mem_rd, pc_en, pc_inc, ir_valid, fetch_err, mem_addr);
    end
    mem_ready = 0; mem_data = '0;
    tick();
    clr = 0;
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h100 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_resume2: rd=%b addr=%h iv=%b required 1 100 0", mem_rd, mem_addr, ir_valid);
    end
    $display("async_clear: resumed at %h", mem_addr);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect();
    test_timeout();
    test_async_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
